peripheral_operand_sequencer: RTL

Controls operand entry and execution for the ALU peripheral. The operator enters eight bytes, four for operand A and four for operand B, LSB first, then one opcode byte, using an 8-bit switch bank and an enter button. The block issues a one-cycle start to the ALU, waits for done with a timeout, and holds the result for display until the next enter. It sits between the button/switch front end and the ALU core.

---
 rtl/peripheral_operand_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/peripheral_operand_sequencer.sv
// Operand entry sequencer for the ALU peripheral: collects two operands and an
// opcode byte-by-byte from switches, launches the ALU and holds its result.
`timescale 1ns/1ps
module peripheral_operand_sequencer #(
  parameter int BYTES_PER_OPERAND = 4,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enter,
  input  logic [7:0]                     inputdata,
  input  logic                           alu_done,
  input  logic [31:0]                    alu_result,
  output logic [8*BYTES_PER_OPERAND-1:0] dataA,
  output logic [8*BYTES_PER_OPERAND-1:0] dataB,
  output logic [3:0]                     opcode,
  output logic                           alu_start,
  output logic [31:0]                    result,
  output logic [2:0]                     byte_index,
  output logic [2:0]                     state_o,
  output logic                           error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] LAST = 3'(BYTES_PER_OPERAND - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    START   = 3'd3,
    WAIT    = 3'd4,
    SHOW    = 3'd5
  } state_t;

  state_t        state;
  logic          enter_q;
  logic          armed;
  logic          epulse;
  logic [CW-1:0] cnt;

  // armed blocks a press that is already held when reset releases
  assign epulse  = enter & ~enter_q & armed;
  assign state_o = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD_A;
      enter_q    <= 1'b0;
      armed      <= 1'b0;
      cnt        <= '0;
      byte_index <= '0;
      dataA      <= '0;
      dataB      <= '0;
      opcode     <= '0;
      result     <= '0;
      alu_start  <= 1'b0;
      error      <= 1'b0;
    end else begin
      enter_q   <= enter;
      armed     <= armed | ~enter;
      alu_start <= 1'b0;
      unique case (state)
        LOAD_A: begin
          if (epulse) begin
            dataA[{byte_index, 3'b000} +: 8] <= inputdata;
            if (byte_index == LAST) begin
              byte_index <= '0;
              state      <= LOAD_B;
            end else begin
              byte_index <= byte_index + 3'd1;
            end
          end
        end
        LOAD_B: begin
          if (epulse) begin
            dataB[{byte_index, 3'b000} +: 8] <= inputdata;
            if (byte_index == LAST) begin
              byte_index <= '0;
              state      <= LOAD_OP;
            end else begin
              byte_index <= byte_index + 3'd1;
            end
          end
        end
        LOAD_OP: begin
          if (epulse) begin
            opcode    <= inputdata[3:0];
            alu_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // done takes priority over a coincident timeout
          if (alu_done) begin
            result <= alu_result;
            state  <= SHOW;
          end else if (cnt == CNT_LAST) begin
            error  <= 1'b1;
            result <= 32'hFFFF_FFFF;
            state  <= SHOW;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHOW: begin
          if (epulse) begin
            dataA      <= '0;
            dataB      <= '0;
            opcode     <= '0;
            byte_index <= '0;
            error      <= 1'b0;
            state      <= LOAD_A;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule
